// File: rtl/hazard_sched.sv
// Hazard scheduler between decode and ID/EX: inserts bubbles, flushes on taken
// branches, freezes the pipe on data-memory waits, and keeps stall statistics.
//
// state  | meaning
// RUN    | normal issue; load-use and branch handling active
// HOLD   | data memory busy; whole pipeline frozen until dmem_ready
module hazard_sched #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       ID_ctlex,
  input  logic [2:0]       ID_ctlm,
  input  logic [1:0]       ID_ctlwb,
  input  logic [4:0]       IFID_rs,
  input  logic [4:0]       IFID_rt,
  input  logic             ID_uses_rt,
  input  logic             IDEX_memread,
  input  logic [4:0]       IDEX_rt,
  input  logic             MEM_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic [3:0]       ctlex_out,
  output logic [2:0]       ctlm_out,
  output logic [1:0]       ctlwb_out,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_timeout
);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  localparam int              WC_W   = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT);

  logic [0:0]       state_q, state_d;
  logic             br_pend_q, br_pend_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             timeout_q, timeout_d;

  logic hazard;
  logic br;
  logic hold_now;
  logic stall_inc;

  assign hazard = IDEX_memread && (IDEX_rt != 5'd0) &&
                  ((IDEX_rt == IFID_rs) || (ID_uses_rt && (IDEX_rt == IFID_rt)));
  assign br     = MEM_branch_taken || br_pend_q;

  // Only entry from RUN looks at dmem_req; once held, readiness alone releases.
  assign hold_now = !dmem_ready && ((state_q == S_HOLD) || dmem_req);

  always_comb begin
    ctlex_out   = ID_ctlex;
    ctlm_out    = ID_ctlm;
    ctlwb_out   = ID_ctlwb;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pipe_hold   = 1'b0;
    stall_inc   = 1'b0;
    state_d     = S_RUN;
    br_pend_d   = 1'b0;
    wait_cnt_d  = '0;
    timeout_d   = timeout_q;

    if (!rst_n) begin
      ctlex_out   = '0;
      ctlm_out    = '0;
      ctlwb_out   = '0;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (hold_now) begin
      pipe_hold  = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      stall_inc  = 1'b1;
      state_d    = S_HOLD;
      // A branch resolving while frozen is remembered and flushed on exit.
      br_pend_d  = br_pend_q || MEM_branch_taken;
      if (state_q == S_RUN) begin
        wait_cnt_d = WC_W'(1);
      end else if (wait_cnt_q != WC_MAX) begin
        wait_cnt_d = wait_cnt_q + WC_W'(1);
      end else begin
        wait_cnt_d = wait_cnt_q;
      end
      if (wait_cnt_d == WC_MAX) begin
        timeout_d = 1'b1;
      end
    end else if (br) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      ctlex_out   = '0;
      ctlm_out    = '0;
      ctlwb_out   = '0;
    end else if (hazard) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ctlex_out  = '0;
      ctlm_out   = '0;
      ctlwb_out  = '0;
      stall_inc  = 1'b1;
    end

    if (stall_inc && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      br_pend_q  <= 1'b0;
      wait_cnt_q <= '0;
      stall_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      br_pend_q  <= br_pend_d;
      wait_cnt_q <= wait_cnt_d;
      stall_q    <= stall_d;
      timeout_q  <= timeout_d;
    end
  end

  assign stall_count = stall_q;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_hazard_sched.sv
// Directed plus randomized check of hazard_sched against a cycle-level
// behavioural model of the hazard, branch and memory-wait rules.
module tb_hazard_sched;

  localparam int TO = 4;
  localparam int CW = 5;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    ID_ctlex;
  logic [2:0]    ID_ctlm;
  logic [1:0]    ID_ctlwb;
  logic [4:0]    IFID_rs;
  logic [4:0]    IFID_rt;
  logic          ID_uses_rt;
  logic          IDEX_memread;
  logic [4:0]    IDEX_rt;
  logic          MEM_branch_taken;
  logic          dmem_req;
  logic          dmem_ready;
  logic [3:0]    ctlex_out;
  logic [2:0]    ctlm_out;
  logic [1:0]    ctlwb_out;
  logic          pc_write;
  logic          ifid_write;
  logic          ifid_flush;
  logic          idex_flush;
  logic          exmem_flush;
  logic          pipe_hold;
  logic [CW-1:0] stall_count;
  logic          mem_timeout;

  always #5 clk = ~clk;

  hazard_sched #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_ctlex(ID_ctlex), .ID_ctlm(ID_ctlm), .ID_ctlwb(ID_ctlwb),
    .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .ID_uses_rt(ID_uses_rt),
    .IDEX_memread(IDEX_memread), .IDEX_rt(IDEX_rt),
    .MEM_branch_taken(MEM_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .ctlex_out(ctlex_out), .ctlm_out(ctlm_out), .ctlwb_out(ctlwb_out),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .pipe_hold(pipe_hold), .stall_count(stall_count), .mem_timeout(mem_timeout)
  );

  int compared   = 0;
  int mismatched = 0;

  // Model state: whether memory is holding us, a remembered branch, length of
  // the current wait, total stalls and the sticky timeout.
  bit m_held;
  bit m_pend;
  int m_wait_len;
  int m_stalls;
  bit m_tmo;

  bit m_waiting, m_br, m_hz;
  logic [3:0] e_ex;
  logic [2:0] e_m;
  logic [1:0] e_wb;
  logic e_pc, e_ifw, e_flush, e_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_comb();
    m_hz = IDEX_memread && IDEX_rt != 0 &&
           (IDEX_rt == IFID_rs || (ID_uses_rt && IDEX_rt == IFID_rt));
    m_br = MEM_branch_taken || m_pend;
    m_waiting = !dmem_ready && (m_held || dmem_req);
    e_ex = ID_ctlex; e_m = ID_ctlm; e_wb = ID_ctlwb;
    e_pc = 1; e_ifw = 1; e_flush = 0; e_hold = 0;
    if (!rst_n) begin
      e_ex = 0; e_m = 0; e_wb = 0; e_pc = 0; e_ifw = 0; e_flush = 1;
    end else if (m_waiting) begin
      e_hold = 1; e_pc = 0; e_ifw = 0;
    end else if (m_br) begin
      e_flush = 1; e_ex = 0; e_m = 0; e_wb = 0;
    end else if (m_hz) begin
      e_pc = 0; e_ifw = 0; e_ex = 0; e_m = 0; e_wb = 0;
    end
  endtask

  task automatic model_seq();
    if (!rst_n) begin
      m_held = 0; m_pend = 0; m_wait_len = 0; m_stalls = 0; m_tmo = 0;
    end else if (m_waiting) begin
      if (m_stalls < SAT) m_stalls++;
      m_pend = m_pend || MEM_branch_taken;
      m_wait_len = m_held ? ((m_wait_len + 1 > TO) ? TO : m_wait_len + 1) : 1;
      if (m_wait_len == TO) m_tmo = 1;
      m_held = 1;
    end else begin
      if (!m_br && m_hz && m_stalls < SAT) m_stalls++;
      m_pend = 0; m_held = 0; m_wait_len = 0;
    end
  endtask

  // Called just after a rising edge with inputs already applied.
  task automatic tick();
    #1;
    model_comb();
    chk("ctlex", ctlex_out, e_ex);
    chk("ctlm", ctlm_out, e_m);
    chk("ctlwb", ctlwb_out, e_wb);
    chk("pc_write", pc_write, e_pc);
    chk("ifid_write", ifid_write, e_ifw);
    chk("ifid_flush", ifid_flush, e_flush);
    chk("idex_flush", idex_flush, e_flush);
    chk("exmem_flush", exmem_flush, e_flush);
    chk("pipe_hold", pipe_hold, e_hold);
    @(posedge clk);
    model_seq();
    #1;
    chk("stall_count", stall_count, m_stalls);
    chk("mem_timeout", mem_timeout, m_tmo);
  endtask

  task automatic idle();
    ID_ctlex = 4'hA; ID_ctlm = 3'h5; ID_ctlwb = 2'h3;
    IFID_rs = 5'd1; IFID_rt = 5'd2; ID_uses_rt = 0;
    IDEX_memread = 0; IDEX_rt = 5'd0;
    MEM_branch_taken = 0; dmem_req = 0; dmem_ready = 1;
  endtask

  initial begin
    rst_n = 0;
    idle();
    tick();
    tick();
    rst_n = 1;
    tick();
    chk("after_rst_ctlex", ctlex_out, 4'hA);

    IDEX_memread = 1; IDEX_rt = 5'd5; IFID_rs = 5'd5;
    tick();
    chk("lu_stall_cnt", stall_count, 1);
    idle(); IDEX_memread = 1; IDEX_rt = 5'd0; IFID_rs = 5'd0;
    tick();
    idle(); IDEX_memread = 1; IDEX_rt = 5'd5; IFID_rt = 5'd5; ID_uses_rt = 0;
    tick();
    ID_uses_rt = 1;
    tick();
    chk("rt_stall_cnt", stall_count, 2);

    idle(); IDEX_memread = 1; IDEX_rt = 5'd5; IFID_rs = 5'd5; MEM_branch_taken = 1;
    tick();
    chk("br_over_lu_cnt", stall_count, 2);

    idle(); dmem_req = 1; dmem_ready = 0;
    repeat (3) tick();
    dmem_ready = 1;
    tick();
    idle();
    tick();
    chk("hold3_cnt", stall_count, 5);

    dmem_req = 1; dmem_ready = 0;
    tick();
    MEM_branch_taken = 1;
    tick();
    MEM_branch_taken = 0;
    tick();
    dmem_ready = 1;
    tick();
    idle();
    tick();
    chk("pend_clear_flush", ifid_flush, 0);
    chk("hold_br_cnt", stall_count, 8);

    dmem_req = 1; dmem_ready = 0;
    repeat (6) tick();
    dmem_ready = 1;
    tick();
    idle();
    tick();
    chk("timeout_sticky", mem_timeout, 1);
    chk("timeout_cnt", stall_count, 14);

    dmem_req = 1; dmem_ready = 0;
    repeat (2) tick();
    rst_n = 0;
    tick();
    rst_n = 1; idle();
    tick();
    chk("rst_mid_hold_tmo", mem_timeout, 0);
    chk("rst_mid_hold_cnt", stall_count, 0);

    for (int i = 0; i < 600; i++) begin
      rst_n            = ($urandom_range(0, 99) != 0);
      ID_ctlex         = 4'($urandom);
      ID_ctlm          = 3'($urandom);
      ID_ctlwb         = 2'($urandom);
      IFID_rs          = 5'($urandom_range(0, 3));
      IFID_rt          = 5'($urandom_range(0, 3));
      ID_uses_rt       = 1'($urandom);
      IDEX_memread     = 1'($urandom);
      IDEX_rt          = 5'($urandom_range(0, 3));
      MEM_branch_taken = ($urandom_range(0, 5) == 0);
      dmem_req         = ($urandom_range(0, 2) != 0);
      dmem_ready       = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
